stopwatch_digits: RTL and testbench

- Debounced-key stopwatch that produces six BCD digit values for the board's six seven-segment decoders, one 4-bit value per HEX position.
- Display format is MM:SS.hh (minutes, seconds, hundredths).
- key[0] starts and stops timing; key[1] clears it.
- The block sits directly upstream of the seven-segment decoder instances. The decoders stay purely combinational and consume digit0..digit5.

---
 rtl/stopwatch_digits.sv | 153 +++++++++++++++
 tb/tb_stopwatch_digits.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_digits.sv
// rtl/stopwatch_digits.sv - debounced-key MM:SS.hh stopwatch driving six BCD digits
module stopwatch_digits #(
   parameter int CLK_HZ          = 50000000,
   parameter int TICK_HZ         = 100,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] key,
   output logic [3:0] digit0,
   output logic [3:0] digit1,
   output logic [3:0] digit2,
   output logic [3:0] digit3,
   output logic [3:0] digit4,
   output logic [3:0] digit5,
   output logic       running,
   output logic       rollover
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int DW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
   localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);

   // per-digit terminal values, digit5 first (MM:SS.hh -> 5 9 5 9 9 9)
   localparam logic [5:0][3:0] DIG_MAX = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] PAUSE = 2'd2;

   logic [1:0]       sync_a;
   logic [1:0]       sync_b;
   logic [1:0]       deb;
   logic [1:0]       press;
   logic [DW-1:0]    deb_cnt [2];
   logic [1:0]       state;
   logic [1:0]       state_nx;
   logic [PW-1:0]    presc;
   logic [5:0][3:0]  dig_q;
   logic [5:0][3:0]  dig_nx;
   logic             carry;
   logic             ss_evt;
   logic             clr_evt;
   logic             tick;
   logic             at_max;

   assign ss_evt  = press[0];
   assign clr_evt = press[1];
   assign tick    = (state == RUN) && (presc == PRE_MAX);
   assign at_max  = (dig_q == DIG_MAX);

   // synchronize both keys, debounce them and flag debounced presses (1->0)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_a     <= 2'b11;
         sync_b     <= 2'b11;
         deb        <= 2'b11;
         press      <= 2'b00;
         deb_cnt[0] <= '0;
         deb_cnt[1] <= '0;
      end else begin
         sync_a <= key;
         sync_b <= sync_a;
         for (int k = 0; k < 2; k++) begin
            press[k] <= 1'b0;
            if (sync_b[k] == deb[k]) begin
               deb_cnt[k] <= '0;
            end else if (deb_cnt[k] == DEB_MAX) begin
               deb[k]     <= sync_b[k];
               deb_cnt[k] <= '0;
               press[k]   <= ~sync_b[k];
            end else begin
               deb_cnt[k] <= deb_cnt[k] + DW'(1);
            end
         end
      end
   end

   // next state; start/stop wins except in PAUSE where clear wins
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (ss_evt) state_nx = RUN;
         RUN:     if (ss_evt) state_nx = PAUSE;
         PAUSE:   if (clr_evt) state_nx = IDLE;
                  else if (ss_evt) state_nx = RUN;
         default: state_nx = IDLE;
      endcase
   end

   // state register and registered running flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         running <= 1'b0;
      end else begin
         state   <= state_nx;
         running <= (state_nx == RUN);
      end
   end

   // prescaler advances only in RUN and holds across a pause
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc <= '0;
      end else if ((state == IDLE && ss_evt) || (state == PAUSE && clr_evt)) begin
         presc <= '0;
      end else if (state == RUN) begin
         presc <= tick ? '0 : presc + PW'(1);
      end
   end

   // ripple the +1 through the BCD digits, each wrapping at its own limit
   always_comb begin
      dig_nx = dig_q;
      carry  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (carry) begin
            if (dig_q[i] == DIG_MAX[i]) begin
               dig_nx[i] = 4'd0;
            end else begin
               dig_nx[i] = dig_q[i] + 4'd1;
               carry     = 1'b0;
            end
         end
      end
   end

   // digit registers and the one-cycle wrap pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dig_q    <= '0;
         rollover <= 1'b0;
      end else begin
         rollover <= tick && at_max;
         if (state == PAUSE && clr_evt) begin
            dig_q <= '0;
         end else if (tick) begin
            dig_q <= dig_nx;
         end
      end
   end

   assign digit0 = dig_q[0];
   assign digit1 = dig_q[1];
   assign digit2 = dig_q[2];
   assign digit3 = dig_q[3];
   assign digit4 = dig_q[4];
   assign digit5 = dig_q[5];

endmodule

// File: tb/tb_stopwatch_digits.sv
// tb/tb_stopwatch_digits.sv - randomized bench for stopwatch_digits against a run-time reference model
module tb_stopwatch_digits;

   localparam int DIV  = 10;
   localparam int DEB  = 4;
   localparam int LAT  = DEB + 3;
   localparam int WRAP = 360000 * DIV;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [1:0] key = 2'b11;
   logic [3:0] digit0, digit1, digit2, digit3, digit4, digit5;
   logic       running, rollover;
   logic [23:0] shown;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: elapsed RUN cycles since last clear, plus state
   int cyc = 0;
   int m_state = 0;
   int m_run = 0;
   bit m_roll = 1'b0;
   bit e_ss, e_clr;
   int ev_ss_at = -1;
   int ev_clr_at = -1;
   int preload_at = -1;
   bit mon_en = 1'b0;

   stopwatch_digits #(
      .CLK_HZ(1000),
      .TICK_HZ(100),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .key(key),
      .digit0(digit0),
      .digit1(digit1),
      .digit2(digit2),
      .digit3(digit3),
      .digit4(digit4),
      .digit5(digit5),
      .running(running),
      .rollover(rollover)
   );

   assign shown = {digit5, digit4, digit3, digit2, digit1, digit0};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] digits_of(input int run);
      int h;
      h = run / DIV;
      return {8'd0, 4'((h / 60000) % 6), 4'((h / 6000) % 10), 4'((h / 1000) % 6),
              4'((h / 100) % 10), 4'((h / 10) % 10), 4'(h % 10)};
   endfunction

   // model: one step per clock edge, events arrive LAT edges after the key is driven
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_state = 0;
         m_run   = 0;
         m_roll  = 1'b0;
      end else begin
         cyc++;
         m_roll = 1'b0;
         if (cyc == preload_at) m_run = 359998 * DIV + (m_run % DIV);
         e_ss  = (cyc == ev_ss_at);
         e_clr = (cyc == ev_clr_at);
         if (m_state == 1) begin
            m_run++;
            if (m_run == WRAP) begin
               m_run  = 0;
               m_roll = 1'b1;
            end
         end
         case (m_state)
            0: if (e_ss) m_state = 1;
            1: if (e_ss) m_state = 2;
            default: begin
               if (e_clr) begin
                  m_state = 0;
                  m_run   = 0;
               end else if (e_ss) begin
                  m_state = 1;
               end
            end
         endcase
      end
   end

   // cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (reset_n && mon_en) begin
         check("digits", 32'(shown), digits_of(m_run));
         check("running", 32'(running), 32'(m_state == 1));
         check("rollover", 32'(rollover), 32'(m_roll));
      end
   end

   task automatic press(input logic [1:0] mask, input int len);
      @(negedge clk);
      key = ~mask;
      if (len >= DEB) begin
         if (mask[0]) ev_ss_at = cyc + LAT;
         if (mask[1]) ev_clr_at = cyc + LAT;
      end
      repeat (len) @(negedge clk);
      key = 2'b11;
      repeat (DEB + 4) @(negedge clk);
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      key = 2'b11;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, e, seen, saw99;
      logic [1:0] m;
      int len;

      do_reset();
      mon_en = 1'b1;
      repeat (50) @(negedge clk);
      check("idle_digits", 32'(shown), 32'h0);
      check("idle_running", 32'(running), 32'h0);
      check("idle_rollover", 32'(rollover), 32'h0);

      // short glitch: no event
      press(2'b01, 2);
      repeat (10) @(negedge clk);
      check("glitch_running", 32'(running), 32'h0);
      check("glitch_digits", 32'(shown), 32'h0);

      // start with latency measurement, then 37 ticks
      @(negedge clk);
      key = 2'b10;
      ev_ss_at = cyc + LAT;
      lat = 0;
      while (!running && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("start_latency_in_range", 32'(lat >= DEB && lat <= DEB + 3), 32'h1);
      repeat (10 - lat) @(negedge clk);
      key = 2'b11;
      wait_cyc(ev_ss_at + 370);
      check("digits_00_00_37", 32'(shown), 32'h000037);

      // pause, then clear from pause
      press(2'b01, 5);
      check("paused_running", 32'(running), 32'h0);
      press(2'b10, 5);
      check("cleared_digits", 32'(shown), 32'h0);

      // 250 ticks with an ignored clear while running
      press(2'b01, 6);
      e = ev_ss_at;
      press(2'b10, 6);
      check("clear_in_run_ignored", 32'(running), 32'h1);
      wait_cyc(e + 2500 - LAT - 1);
      press(2'b01, 5);
      check("pause_at_2_50", 32'(shown), 32'h000250);
      repeat (30) @(negedge clk);
      check("pause_holds", 32'(shown), 32'h000250);
      press(2'b10, 5);
      check("clear_after_pause", 32'(shown), 32'h0);
      check("clear_running", 32'(running), 32'h0);

      // preload 59:59.98 while paused, resume and watch the wrap
      press(2'b01, 5);
      repeat (37) @(negedge clk);
      press(2'b01, 5);
      @(negedge clk);
      #2;
      force dut.dig_q = 24'h595998;
      preload_at = cyc + 1;
      @(negedge clk);
      #2;
      release dut.dig_q;
      @(negedge clk);
      check("preload", 32'(shown), 32'h595998);
      key = 2'b10;
      ev_ss_at = cyc + LAT;
      repeat (5) @(negedge clk);
      key = 2'b11;
      seen = 0;
      saw99 = 0;
      for (int i = 0; i < 60 && seen == 0; i++) begin
         @(negedge clk);
         if (shown == 24'h595999) saw99 = 1;
         if (rollover) seen = 1;
      end
      check("saw_59_59_99", 32'(saw99), 32'h1);
      check("rollover_seen", 32'(seen), 32'h1);
      check("wrap_digits", 32'(shown), 32'h0);
      check("wrap_running", 32'(running), 32'h1);
      @(negedge clk);
      check("rollover_one_cycle", 32'(rollover), 32'h0);

      // simultaneous presses: RUN -> PAUSE, PAUSE -> IDLE
      repeat (40) @(negedge clk);
      press(2'b11, 6);
      check("both_in_run_pauses", 32'(running), 32'h0);
      check("both_in_run_holds", 32'(shown), digits_of(m_run));
      press(2'b11, 6);
      check("both_in_pause_clears", 32'(shown), 32'h0);
      check("both_in_pause_idle", 32'(running), 32'h0);

      // randomized key traffic
      for (int i = 0; i < 40; i++) begin
         m = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 3) == 0) len = $urandom_range(1, DEB - 1);
         else len = $urandom_range(DEB, DEB + 8);
         press(m, len);
         repeat ($urandom_range(0, 300)) @(negedge clk);
      end

      // asynchronous reset mid-count at 00:01.23
      do_reset();
      press(2'b01, 5);
      wait_cyc(ev_ss_at + 1233);
      check("pre_reset_1_23", 32'(shown), 32'h000123);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_reset_digits", 32'(shown), 32'h0);
      check("async_reset_running", 32'(running), 32'h0);
      check("async_reset_rollover", 32'(rollover), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
